debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//
// Purpose:
//   A bank of N_BTN independent button debouncers. Each raw input is brought
//   into the clk domain through a two-flop synchroniser. The synchronised
//   level must disagree with the accepted level for DEBOUNCE_CYCLES
//   consecutive clocks before the new level is accepted. Edge pulses, a
//   press-toggled state and an optional long-press pulse are derived from
//   the accepted level.
//
// Optional feature:
//   DEBOUNCE_LONG_PRESS_EN - when defined, each channel gets a hold counter
//   and long_o pulses once per press after LONG_CYCLES clocks of accepted-high
//   level. When undefined, no hold counters exist and long_o is tied to 0.
//
// Parameters:
//   N_BTN            number of independent channels (1..32)
//   DEBOUNCE_CYCLES  clocks of disagreement needed to accept a level (>=2)
//   LONG_CYCLES      accepted-high clocks that qualify as a long press
//
// Ports:
//   clk       system clock, rising edge active
//   rst       asynchronous active-high reset
//   btn_raw   unsynchronised button inputs, bit i = channel i
//   level_o   debounced level per channel
//   rise_o    one-clock pulse when level_o[i] goes 0->1
//   fall_o    one-clock pulse when level_o[i] goes 1->0
//   toggle_o  per-channel state inverted on every accepted press
//   long_o    one-clock pulse when a press reaches LONG_CYCLES
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] rise_o,
  output logic [N_BTN-1:0] fall_o,
  output logic [N_BTN-1:0] toggle_o,
  output logic [N_BTN-1:0] long_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s0;
  logic [N_BTN-1:0] s1;

  // Two-flop synchroniser for every raw input. Only s1 is allowed to reach
  // the debounce logic so that metastability on s0 never propagates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          rise;
    logic          fall;
    logic          tog;

    // Stability counter and accepted level. The counter only advances while
    // the synchronised input disagrees with the accepted level and is reset
    // by any single clock of agreement, so short bounces leave no trace.
    // On the last disagreeing clock the new level is taken, the counter is
    // cleared (so it can never wrap) and exactly one of rise/fall is raised
    // for that one clock. Presses also flip the toggle state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        lvl  <= 1'b0;
        rise <= 1'b0;
        fall <= 1'b0;
        tog  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (s1[i] != lvl) begin
          if (cnt == DB_LAST) begin
            lvl  <= s1[i];
            cnt  <= '0;
            rise <= s1[i];
            fall <= ~s1[i];
            if (s1[i]) begin
              tog <= ~tog;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign level_o[i]  = lvl;
    assign rise_o[i]   = rise;
    assign fall_o[i]   = fall;
    assign toggle_o[i] = tog;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hcnt;
    logic          lng;

    // Hold counter measures how long the accepted level has been high. It
    // saturates at LONG_CYCLES, so the long pulse can only fire once on the
    // LONG_CYCLES-1 -> LONG_CYCLES step and never repeats while held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hcnt <= '0;
        lng  <= 1'b0;
      end else begin
        lng <= 1'b0;
        if (lvl) begin
          if (hcnt != HOLD_MAX) begin
            hcnt <= hcnt + HW'(1);
          end
          if (hcnt == HOLD_LAST) begin
            lng <= 1'b1;
          end
        end else begin
          hcnt <= '0;
        end
      end
    end

    assign long_o[i] = lng;
`else
    assign long_o[i] = 1'b0;
`endif
  end

endmodule
